// File: rtl/fir_l2_out_serializer.sv
// Pair-to-sample serializer: buffers DEPTH {s0,s1} pairs from the two-sample
// FIR datapath and emits them one sample per beat, s0 first, under backpressure.
module fir_l2_out_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_s0,
  input  logic [DATA_WIDTH-1:0]      in_s1,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_phase,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a pair moves when in_valid && in_ready at a rising edge; a sample
  // moves when out_valid && out_ready. in_ready/out_valid come from registered
  // count only, so neither side ever sees a combinational path from the other.
  typedef enum logic {
    PH_S0 = 1'b0,
    PH_S1 = 1'b1
  } phase_t;

  phase_t          phase, phase_next;
  logic [PW-1:0]   wr_ptr, wr_next;
  logic [PW-1:0]   rd_ptr, rd_next;
  logic [CW-1:0]   count, count_next;

  logic [DATA_WIDTH-1:0] mem_s0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem_s1 [DEPTH];

  logic push;
  logic pop;
  logic pop_last;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_phase = (phase == PH_S1);
  assign level     = count;

  // Flush wins over both sides, so the pair offered in a flush cycle is dropped.
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;
  assign pop_last = pop && (phase == PH_S1);

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = (phase == PH_S1) ? mem_s1[rd_ptr] : mem_s0[rd_ptr];
    end
  end

  always_comb begin
    phase_next = phase;
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    count_next = count;
    if (flush) begin
      phase_next = PH_S0;
      wr_next    = '0;
      rd_next    = '0;
      count_next = '0;
    end else begin
      if (push) begin
        wr_next = wr_ptr + PW'(1);
      end
      if (pop) begin
        if (phase == PH_S0) begin
          phase_next = PH_S1;
        end else begin
          // The head pair is released only once its s1 has left.
          phase_next = PH_S0;
          rd_next    = rd_ptr + PW'(1);
        end
      end
      if (push && !pop_last) begin
        count_next = count + CW'(1);
      end else if (!push && pop_last) begin
        count_next = count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= PH_S0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      phase  <= phase_next;
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= count_next;
    end
  end

  // Sample storage is not reset; only valid entries are ever read out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_s0[wr_ptr] <= in_s0;
      mem_s1[wr_ptr] <= in_s1;
    end
  end

endmodule

// File: doc/fir_l2_out_serializer.md
# fir_l2_out_serializer

Output-side rate converter for the two-sample-per-clock FIR datapath. It accepts one pair of filtered samples per handshake, buffers up to DEPTH pairs, and emits them as a single-sample-per-beat valid/ready stream, earlier sample first. It sits between the L=2 parallel filter output registers and the serial sink (DAC interface or capture FIFO), absorbing sink backpressure.

## Interface
- DATA_WIDTH, 16, sample width (signed Q15 by default, passed through unmodified)
- DEPTH, 4, pair-buffer depth in pairs; power of two, >= 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- flush  in  1  synchronous clear of buffer contents and phase
- in_valid  in  1  pair available
- in_ready  out  1  pair can be accepted this cycle
- in_s0  in  DATA_WIDTH  earlier-in-time sample of the pair
- in_s1  in  DATA_WIDTH  later-in-time sample of the pair
- out_valid  out  1  out_data holds a valid sample
- out_ready  in  1  sink accepts out_data
- out_data  out  DATA_WIDTH  serialized sample
- out_phase  out  1  0 = out_data is an s0 sample, 1 = an s1 sample
- level  out  $clog2(DEPTH)+1  pairs currently held (including a half-consumed head)

## Operation
- Storage: DEPTH-entry register array of {s0,s1}; wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap), count (0..DEPTH), phase bit.
- Push: in_valid && in_ready -> mem[wr_ptr] <= {in_s0,in_s1}; wr_ptr++.
- in_ready = (count != DEPTH); depends on count only, never on out_ready (no pass-through when full).
- out_valid = (count != 0); out_data = phase ? mem[rd_ptr].s1 : mem[rd_ptr].s0; out_data = 0 when out_valid = 0; out_phase = phase.
- Pop beat: out_valid && out_ready:
  - phase 0 -> phase <= 1; pointers and count unchanged.
  - phase 1 -> phase <= 0; rd_ptr++; count--.
- count update: +1 on push, -1 on phase-1 pop, unchanged when both occur in the same cycle or neither.
- A pair is freed only after its s1 beat; a half-consumed head still counts toward level and full.
- Flush: count, wr_ptr, rd_ptr, phase <= 0 on the next edge; overrides any push or pop in the same cycle (the pair offered that cycle is discarded even if in_ready was 1).
- Data is never modified: no rounding, saturation, or sign handling; bit-exact pass-through.
- Reset (rst = 0, asynchronous): count, pointers, phase <= 0; mem contents need not be cleared. While reset is asserted: out_valid = 0, out_data = 0, out_phase = 0, level = 0, in_ready = 1. A reset mid-stream discards all buffered and half-consumed pairs.

## Timing
- Latency: pair pushed at edge N -> out_valid = 1 with its s0 in cycle after edge N; s1 one cycle after the s0 beat is accepted at the earliest.
- Empty-buffer push does not fall through combinationally (out_valid is 0 in the push cycle).
- Throughput: 1 sample/cycle out at out_ready = 1; sustained input rate 1 pair per 2 cycles. Back-to-back pushes fill the buffer at 1 pair/cycle until full.
- Full + phase-1 pop in same cycle: in_ready stays 0 that cycle; becomes 1 the next cycle.
- out_data and out_valid must remain stable while out_valid = 1 and out_ready = 0.
- in_ready, out_valid, level derive from registered state only.

## Test plan
- Reset then push {s0=0x1111,s1=0x2222}, out_ready=1 -> out_data 0x1111 (phase 0) then 0x2222 (phase 1) on consecutive cycles, then out_valid=0, level 1->1->0.
- out_ready=0, push 4 pairs 0x0001..0x0008 at 1 pair/cycle -> level=4, in_ready=0 after 4th push; 5th offered pair not accepted; then out_ready=1 -> 0x0001..0x0008 in order, in_ready returns 1 cycle after the 0x0002 beat.
- Continuous input 1 pair/2 cycles, random out_ready (50%) for 1000 pairs -> output sequence equals input s0,s1 interleaving, no loss/duplication, stable data during stalls.
- Full buffer, phase=1, push offered while s1 popped -> push not accepted that cycle, accepted next cycle, level 4->3->4.
- Two pairs buffered, head half-consumed, assert flush with in_valid=1 -> next cycle level=0, out_valid=0, phase=0, offered pair dropped; next push emits its s0 first.
- Assert rst=0 asynchronously mid-beat with 3 pairs held -> outputs go to reset values without a clock edge; after release, first pushed pair 0x7FFF/0x8000 emerges as 0x7FFF then 0x8000.
